// File: rtl/goldschmidt_sqrt_unit_if.sv
// Request/response bundle for goldschmidt_sqrt_unit: operand side, result side and flush.
interface goldschmidt_sqrt_unit_if #(
  parameter int unsigned MW       = 8,
  parameter int unsigned TAG_W    = 2,
  parameter int unsigned MAX_ITER = 4
);
  localparam int unsigned IW = $clog2(MAX_ITER + 1);

  logic             valid_i;
  logic             ready_o;
  logic [MW-1:0]    s_i;
  logic             exp_odd_i;
  logic             inv_i;
  logic             special_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             valid_o;
  logic             ready_i;
  logic [MW-1:0]    res_o;
  logic [TAG_W-1:0] tag_o;
  logic [IW-1:0]    iter_o;
  logic             inexact_o;

  modport master (
    output valid_i, s_i, exp_odd_i, inv_i, special_i, tag_i, flush_i, ready_i,
    input  ready_o, valid_o, res_o, tag_o, iter_o, inexact_o
  );

  modport slave (
    input  valid_i, s_i, exp_odd_i, inv_i, special_i, tag_i, flush_i, ready_i,
    output ready_o, valid_o, res_o, tag_o, iter_o, inexact_o
  );
endinterface

// File: rtl/goldschmidt_sqrt_unit.sv
// Iterative Goldschmidt sqrt / inverse-sqrt on a Q1.(MW-1) significand, with odd-exponent
// correction, round-to-nearest output, flush and valid/ready handshakes on both sides.
module goldschmidt_sqrt_unit #(
  parameter int unsigned MW       = 8,
  parameter int unsigned GW       = 8,
  parameter int unsigned MAX_ITER = 4,
  parameter int unsigned TAG_W    = 2
) (
  input logic                  clk,
  input logic                  rst,
  goldschmidt_sqrt_unit_if.slave bus
);
  localparam int unsigned W  = MW + GW;
  localparam int unsigned IW = $clog2(MAX_ITER + 1);

  localparam logic [W-1:0] ONE       = {1'b1, {(W - 1){1'b0}}};
  localparam logic [W:0]   THREE     = {2'b11, {(W - 1){1'b0}}};
  localparam logic [W-1:0] SQRT2     = W'($rtoi(1.4142135623730951 * (2.0 ** (W - 1)) + 0.5));
  localparam logic [W-1:0] INV_SQRT2 = W'($rtoi(0.7071067811865476 * (2.0 ** (W - 1)) + 0.5));

  typedef enum logic [2:0] {StIdle, StItB, StItR, StItXy, StFix, StDone} state_e;

  // Full 2W-bit product, truncated back to Q1.(W-1).
  function automatic logic [W-1:0] mul_q(input logic [W-1:0] a, input logic [W-1:0] c);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, c};
    return W'(p >> (W - 1));
  endfunction

  // (3 - b) / 2 with an unsigned (W+1)-bit subtraction.
  function automatic logic [W-1:0] half_rem(input logic [W-1:0] b);
    logic [W:0] d;
    d = THREE - {1'b0, b};
    return W'(d >> 1);
  endfunction

  state_e           state_q, state_d;
  logic [W-1:0]     b_q, b_d, r_q, r_d, x_q, x_d, y_q, y_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic             exp_odd_q, exp_odd_d, inv_q, inv_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [MW-1:0]    res_q, res_d;
  logic             inexact_q, inexact_d;
  logic             valid_q, valid_d;

  logic             ready;
  logic             accept;
  logic [W-1:0]     b_in, r_in;
  logic [W-1:0]     v_sel, v_fix;
  logic [MW:0]      rnd;

  assign ready  = (state_q == StIdle) && !rst;
  assign accept = bus.valid_i && ready && !bus.flush_i;

  assign b_in = {bus.s_i, {GW{1'b0}}};
  assign r_in = half_rem(b_in);

  assign v_sel = inv_q ? y_q : x_q;
  assign v_fix = exp_odd_q ? mul_q(v_sel, inv_q ? INV_SQRT2 : SQRT2) : v_sel;
  assign rnd   = {1'b0, v_fix[W-1 -: MW]} + (MW + 1)'(v_fix[GW-1]);

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    r_d       = r_q;
    x_d       = x_q;
    y_d       = y_q;
    iter_d    = iter_q;
    exp_odd_d = exp_odd_q;
    inv_d     = inv_q;
    tag_d     = tag_q;
    res_d     = res_q;
    inexact_d = inexact_q;
    valid_d   = valid_q;

    if (bus.flush_i && state_q != StIdle) begin
      state_d = StIdle;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            exp_odd_d = bus.exp_odd_i;
            inv_d     = bus.inv_i;
            tag_d     = bus.tag_i;
            iter_d    = '0;
            if (bus.special_i) begin
              res_d     = '0;
              inexact_d = 1'b0;
              valid_d   = 1'b1;
              state_d   = StDone;
            end else begin
              b_d     = b_in;
              r_d     = r_in;
              x_d     = mul_q(b_in, r_in);
              y_d     = r_in;
              state_d = StItB;
            end
          end
        end
        StItB: begin
          if (r_q == ONE || iter_q == IW'(MAX_ITER)) begin
            state_d = StFix;
          end else begin
            b_d     = mul_q(mul_q(b_q, r_q), r_q);
            state_d = StItR;
          end
        end
        StItR: begin
          r_d     = half_rem(b_q);
          state_d = StItXy;
        end
        StItXy: begin
          x_d     = mul_q(x_q, r_q);
          y_d     = mul_q(y_q, r_q);
          iter_d  = iter_q + IW'(1);
          state_d = StItB;
        end
        StFix: begin
          // A carry out of the rounder would read as 2.0; clamp to the largest significand.
          res_d     = rnd[MW] ? '1 : rnd[MW-1:0];
          inexact_d = |v_fix[GW-1:0];
          valid_d   = 1'b1;
          state_d   = StDone;
        end
        StDone: begin
          if (bus.ready_i) begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      b_q       <= '0;
      r_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      iter_q    <= '0;
      exp_odd_q <= 1'b0;
      inv_q     <= 1'b0;
      tag_q     <= '0;
      res_q     <= '0;
      inexact_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      r_q       <= r_d;
      x_q       <= x_d;
      y_q       <= y_d;
      iter_q    <= iter_d;
      exp_odd_q <= exp_odd_d;
      inv_q     <= inv_d;
      tag_q     <= tag_d;
      res_q     <= res_d;
      inexact_q <= inexact_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.ready_o   = ready;
  assign bus.valid_o   = valid_q;
  assign bus.res_o     = res_q;
  assign bus.tag_o     = tag_q;
  assign bus.iter_o    = iter_q;
  assign bus.inexact_o = inexact_q;
endmodule
